// File: rtl/fft256_reorder.sv
// fft256_reorder: turns the bit-reversed frame stream coming out of the
// radix-2^2 SDF FFT into natural bin order using a two-bank ping-pong buffer.
// The writer fills one bank while the reader replays the other. Back-to-back
// frames flow through without a bubble.
module fft256_reorder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG2N = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG2N-1:0] do_idx,
  output logic             drop
);

  localparam int unsigned N       = 1 << LOG2N;
  localparam int unsigned DEPTH   = 2 * N;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } sample_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_e;

  // Reverse the LOG2N address bits.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  // Ping-pong storage; bank select is the address MSB.
  sample_t mem [DEPTH];

  // Write side state
  logic [LOG2N-1:0] w_cnt_q;
  logic             wbank_q;
  logic             drop_q;
  logic [1:0]       full_q;
  logic [1:0]       full_d;

  // Read side state
  rd_state_e        state_q;
  logic             rbank_q;
  logic [LOG2N-1:0] r_cnt_q;

  // Output pipeline registers
  logic             do_en_q;
  sample_t          rd_data_q;
  logic [LOG2N-1:0] do_idx_q;

  // Combinational control
  logic             wr_last_c;
  logic             wr_abort_c;
  logic             rd_issue_c;
  logic             rd_bank_c;
  logic [LOG2N-1:0] rd_cnt_c;
  logic             rd_done_c;
  logic             rd_chain_c;

  // Write-side events: frame completion and mid-frame abort.
  always_comb begin
    wr_last_c  = di_en && (w_cnt_q == CNT_LAST);
    wr_abort_c = !di_en && (w_cnt_q != '0);
  end

  // Read issue: IDLE starts the chosen full bank at index 0 in the same cycle
  // it sees the flag, so the first sample appears two cycles after the last input.
  always_comb begin
    rd_issue_c = 1'b0;
    rd_bank_c  = rbank_q;
    rd_cnt_c   = r_cnt_q;
    rd_done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q != 2'b00) begin
          rd_issue_c = 1'b1;
          rd_cnt_c   = '0;
          if (full_q == 2'b11) begin
            rd_bank_c = ~wbank_q;
          end else begin
            rd_bank_c = full_q[1];
          end
        end
      end
      S_READ: begin
        rd_issue_c = 1'b1;
        rd_done_c  = (r_cnt_q == CNT_LAST);
      end
      default: begin
        rd_issue_c = 1'b0;
      end
    endcase
  end

  // Other bank is ready now, or completes on this very edge.
  always_comb begin
    rd_chain_c = full_q[~rbank_q] || (wr_last_c && (wbank_q != rbank_q));
  end

  // Full flags: reader clears its bank on the last read, writer sets on completion.
  always_comb begin
    full_d = full_q;
    if (rd_done_c) begin
      full_d[rbank_q] = 1'b0;
    end
    if (wr_last_c) begin
      full_d[wbank_q] = 1'b1;
    end
  end

  // Write counter, bank toggle and drop pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_cnt_q <= '0;
      wbank_q <= 1'b0;
      drop_q  <= 1'b0;
      full_q  <= 2'b00;
    end else begin
      drop_q <= wr_abort_c;
      full_q <= full_d;
      if (di_en) begin
        w_cnt_q <= w_cnt_q + CNT_ONE;
        if (wr_last_c) begin
          wbank_q <= ~wbank_q;
        end
      end else begin
        w_cnt_q <= '0;
      end
    end
  end

  // Sample storage; partial frames are simply overwritten by the next one.
  always_ff @(posedge clock) begin
    if (di_en && !reset) begin
      mem[{wbank_q, w_cnt_q}] <= '{re: di_re, im: di_im};
    end
  end

  // Reader FSM: walks r_cnt over a bank and chains straight into the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rbank_q <= 1'b0;
      r_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_issue_c) begin
            state_q <= S_READ;
            rbank_q <= rd_bank_c;
            r_cnt_q <= CNT_ONE;
          end
        end
        S_READ: begin
          if (rd_done_c) begin
            r_cnt_q <= '0;
            if (rd_chain_c) begin
              rbank_q <= ~rbank_q;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            r_cnt_q <= r_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Synchronous RAM read plus output registers; outputs are zero when not valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      do_en_q   <= 1'b0;
      rd_data_q <= '0;
      do_idx_q  <= '0;
    end else begin
      do_en_q <= rd_issue_c;
      if (rd_issue_c) begin
        rd_data_q <= mem[{rd_bank_c, bitrev(rd_cnt_c)}];
        do_idx_q  <= rd_cnt_c;
      end else begin
        rd_data_q <= '0;
        do_idx_q  <= '0;
      end
    end
  end

  assign do_en  = do_en_q;
  assign do_re  = rd_data_q.re;
  assign do_im  = rd_data_q.im;
  assign do_idx = do_idx_q;
  assign drop   = drop_q;

  // The writer must never land on a bank still waiting to be read.
  a_no_overwrite: assert property (@(posedge clock) disable iff (reset)
    !(di_en && full_q[wbank_q]));

endmodule

// File: tb/tb_fft256_reorder.sv
// Bench for fft256_reorder: drives frames, gaps, aborts and resets, and compares
// every output cycle against a frame-level reference model.
module tb_fft256_reorder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LOG2N = 8;
  localparam int unsigned N     = 256;
  localparam int unsigned MAXC  = 16384;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             di_en = 1'b0;
  logic [WIDTH-1:0] di_re = '0;
  logic [WIDTH-1:0] di_im = '0;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [LOG2N-1:0] do_idx;
  logic             drop;

  int errors   = 0;
  int checks   = 0;
  int edge_cnt = 0;
  int wcnt     = 0;
  int prev_end = 0;
  int last_start = 0;
  int mon_k;
  int tgt;
  bit chk_on = 1'b0;

  // Expected output per cycle, keyed by the clock edge that precedes it.
  logic             exp_en   [MAXC];
  logic [WIDTH-1:0] exp_re   [MAXC];
  logic [WIDTH-1:0] exp_im   [MAXC];
  int               exp_idx  [MAXC];
  logic             exp_drop [MAXC];

  // Samples of the frame currently being sent, in arrival order.
  logic [WIDTH-1:0] fr_re [N];
  logic [WIDTH-1:0] fr_im [N];

  fft256_reorder #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clock  (clock),
    .reset  (reset),
    .di_en  (di_en),
    .di_re  (di_re),
    .di_im  (di_im),
    .do_en  (do_en),
    .do_re  (do_re),
    .do_im  (do_im),
    .do_idx (do_idx),
    .drop   (drop)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic int bitrev_ref(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
    end
  endtask

  // A completed frame is replayed in natural order: bin i is the sample that
  // arrived at position bitrev(i). Output starts 2 cycles after the last input
  // or right after the previous frame's output, whichever is later.
  task automatic schedule(input int e);
    int start;
    start = (e + 1 > prev_end + 1) ? e + 1 : prev_end + 1;
    for (int i = 0; i < N; i++) begin
      if (start + i < MAXC) begin
        exp_en[start + i]  = 1'b1;
        exp_re[start + i]  = fr_re[bitrev_ref(i)];
        exp_im[start + i]  = fr_im[bitrev_ref(i)];
        exp_idx[start + i] = i;
      end
    end
    last_start = start;
    prev_end   = start + N - 1;
  endtask

  task automatic drive(input logic en, input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
    int e;
    @(posedge clock);
    #1;
    di_en = en;
    di_re = re;
    di_im = im;
    e = edge_cnt + 1;
    if (en) begin
      fr_re[wcnt] = re;
      fr_im[wcnt] = im;
      wcnt++;
      if (wcnt == N) begin
        schedule(e);
        wcnt = 0;
      end
    end else if (wcnt != 0) begin
      if (e < MAXC) exp_drop[e] = 1'b1;
      wcnt = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, '0, '0);
  endtask

  // kind 0: p / -p, kind 1: p+256 / -(p+256), otherwise random.
  task automatic send_frame(input int kind, input int len);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] m;
    for (int p = 0; p < len; p++) begin
      case (kind)
        0: begin r = WIDTH'(p); m = WIDTH'(-p); end
        1: begin r = WIDTH'(p + 256); m = WIDTH'(-(p + 256)); end
        default: begin r = WIDTH'($urandom); m = WIDTH'($urandom); end
      endcase
      drive(1'b1, r, m);
    end
  endtask

  // One-cycle reset: everything scheduled from the reset edge on is cancelled.
  task automatic apply_reset();
    int e;
    @(posedge clock);
    #1;
    reset = 1'b1;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;
    e = edge_cnt + 1;
    for (int k = e; k < MAXC; k++) begin
      exp_en[k]   = 1'b0;
      exp_re[k]   = '0;
      exp_im[k]   = '0;
      exp_idx[k]  = 0;
      exp_drop[k] = 1'b0;
    end
    wcnt     = 0;
    prev_end = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Compare every output on the falling edge.
  always @(negedge clock) begin
    if (chk_on) begin
      mon_k = edge_cnt;
      if (mon_k < MAXC) begin
        check_eq("do_en",  32'(do_en),  32'(exp_en[mon_k]));
        check_eq("do_re",  32'(do_re),  32'(exp_re[mon_k]));
        check_eq("do_im",  32'(do_im),  32'(exp_im[mon_k]));
        check_eq("do_idx", 32'(do_idx), 32'(exp_idx[mon_k]));
        check_eq("drop",   32'(drop),   32'(exp_drop[mon_k]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      exp_en[k]   = 1'b0;
      exp_re[k]   = '0;
      exp_im[k]   = '0;
      exp_idx[k]  = 0;
      exp_drop[k] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_on = 1'b1;
    idle(5);

    // Single frame with the positional ramp.
    send_frame(0, N);
    idle(300);

    // Two frames back-to-back.
    send_frame(0, N);
    send_frame(1, N);
    idle(300);

    // Aborted partial frame, then a full one.
    send_frame(2, 100);
    idle(3);
    send_frame(2, N);
    idle(300);

    // Idle gap of 50 cycles between frames.
    send_frame(2, N);
    idle(50);
    send_frame(2, N);
    idle(300);

    // Reset while output sample 40 is on the bus, then a clean frame.
    send_frame(2, N);
    tgt = last_start + 39;
    while (edge_cnt < tgt) drive(1'b0, '0, '0);
    apply_reset();
    idle(10);
    send_frame(2, N);
    idle(300);

    // Reset during a partial write: no drop pulse, nothing replayed.
    send_frame(2, 77);
    apply_reset();
    idle(20);

    // Random mix of partial frames and short gaps.
    repeat (4) begin
      if ($urandom_range(0, 1) == 1) begin
        send_frame(2, int'($urandom_range(1, N - 1)));
        idle(int'($urandom_range(1, 3)));
      end
      send_frame(2, N);
      idle(int'($urandom_range(0, 3)));
    end
    idle(600);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
